// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE-754 divider: radix-2 restoring mantissa division, RNE rounding,
// flush-to-zero denormals, valid/ready handshakes on both sides.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] opd1,
  input  logic [W-1:0] opd2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         overflow,
  output logic         underflow,
  output logic         div_by_zero,
  output logic         invalid
);

  localparam int EW2   = EXP_W + 2;
  localparam int QW    = MAN_W + 3;
  localparam int RW    = MAN_W + 2;
  localparam int CNT_W = $clog2(MAN_W + 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_ROUND  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic signed [EW2-1:0] E_BIAS = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] E_MAX  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] E_ONE  = EW2'(1);
  localparam logic signed [EW2-1:0] E_ZERO = '0;
  localparam logic [CNT_W-1:0]      LAST   = CNT_W'(MAN_W + 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [1:0]            state_reg;
  logic                  sign_reg;
  logic signed [EW2-1:0] e_reg;
  logic [MAN_W:0]        mb_reg;
  logic [RW-1:0]         rem_reg;
  logic [QW-1:0]         q_reg;
  logic [CNT_W-1:0]      cnt_reg;

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);

  // Operand classification; exp==0 is treated as zero regardless of fraction.
  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] f1, f2;
  logic zero1, zero2, inf1, inf2, nan1, nan2, special, sgn;

  assign e1      = opd1[W-2:MAN_W];
  assign e2      = opd2[W-2:MAN_W];
  assign f1      = opd1[MAN_W-1:0];
  assign f2      = opd2[MAN_W-1:0];
  assign zero1   = (e1 == '0);
  assign zero2   = (e2 == '0);
  assign inf1    = (&e1) && (f1 == '0);
  assign inf2    = (&e2) && (f2 == '0);
  assign nan1    = (&e1) && (f1 != '0);
  assign nan2    = (&e2) && (f2 != '0);
  assign special = zero1 || zero2 || (&e1) || (&e2);
  assign sgn     = opd1[W-1] ^ opd2[W-1];

  logic [W-1:0] sp_res;
  logic         sp_inv, sp_dbz;

  always_comb begin
    sp_res = {sgn, {(W-1){1'b0}}};
    sp_inv = 1'b0;
    sp_dbz = 1'b0;
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
      sp_res = QNAN;
      sp_inv = 1'b1;
    end else if (zero2 && !inf1) begin
      sp_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      sp_dbz = 1'b1;
    end else if (inf1) begin
      sp_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // One restoring step; the first step runs in IDLE straight off the inputs.
  logic [RW-1:0]  it_rem, it_rem_next;
  logic [MAN_W:0] it_mb;
  logic           it_q;

  always_comb begin
    it_rem      = (state_reg == S_IDLE) ? {1'b0, 1'b1, f1} : rem_reg;
    it_mb       = (state_reg == S_IDLE) ? {1'b1, f2} : mb_reg;
    it_q        = (it_rem >= {1'b0, it_mb});
    it_rem_next = (it_q ? (it_rem - {1'b0, it_mb}) : it_rem) << 1;
  end

  logic signed [EW2-1:0] e_calc;
  assign e_calc = $signed({2'b00, e1}) - $signed({2'b00, e2}) + E_BIAS;

  logic [MAN_W-1:0]      frac_pre, frac_fin;
  logic [MAN_W:0]        frac_sum;
  logic                  guard, sticky, inc, rnd_ovf, rnd_unf;
  logic signed [EW2-1:0] e_norm, e_rnd;
  logic [W-1:0]          rnd_res;

  always_comb begin
    if (q_reg[QW-1]) begin
      frac_pre = q_reg[MAN_W+1:2];
      guard    = q_reg[1];
      sticky   = q_reg[0] || (rem_reg != '0);
      e_norm   = e_reg;
    end else begin
      frac_pre = q_reg[MAN_W:1];
      guard    = q_reg[0];
      sticky   = (rem_reg != '0);
      e_norm   = e_reg - E_ONE;
    end
    inc      = guard && (sticky || frac_pre[0]);
    frac_sum = {1'b0, frac_pre} + {{MAN_W{1'b0}}, inc};
    if (frac_sum[MAN_W]) begin
      frac_fin = '0;
      e_rnd    = e_norm + E_ONE;
    end else begin
      frac_fin = frac_sum[MAN_W-1:0];
      e_rnd    = e_norm;
    end
    rnd_ovf = (e_rnd >= E_MAX);
    rnd_unf = (e_rnd <= E_ZERO);
    if (rnd_ovf)      rnd_res = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (rnd_unf) rnd_res = {sign_reg, {(W-1){1'b0}}};
    else              rnd_res = {sign_reg, e_rnd[EXP_W-1:0], frac_fin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      sign_reg    <= 1'b0;
      e_reg       <= '0;
      mb_reg      <= '0;
      rem_reg     <= '0;
      q_reg       <= '0;
      cnt_reg     <= '0;
      res         <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (in_valid) begin
          sign_reg    <= sgn;
          overflow    <= 1'b0;
          underflow   <= 1'b0;
          div_by_zero <= 1'b0;
          invalid     <= 1'b0;
          if (special) begin
            res         <= sp_res;
            div_by_zero <= sp_dbz;
            invalid     <= sp_inv;
            state_reg   <= S_DONE;
          end else begin
            e_reg     <= e_calc;
            mb_reg    <= {1'b1, f2};
            rem_reg   <= it_rem_next;
            q_reg     <= {{(QW-1){1'b0}}, it_q};
            cnt_reg   <= '0;
            state_reg <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem_reg <= it_rem_next;
          q_reg   <= {q_reg[QW-2:0], it_q};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) state_reg <= S_ROUND;
        end
        S_ROUND: begin
          res       <= rnd_res;
          overflow  <= rnd_ovf;
          underflow <= rnd_unf && !rnd_ovf;
          state_reg <= S_DONE;
        end
        S_DONE: if (out_ready) state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: single-precision vector table with scoreboard, handshake
// and mid-operation reset sequences, plus a half-precision instance.
module tb_fp_div_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] opd1, opd2, res;
  logic        overflow, underflow, div_by_zero, invalid;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_opd1, h_opd2, h_res;
  logic        h_overflow, h_underflow, h_div_by_zero, h_invalid;

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opd1(opd1), .opd2(opd2), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .overflow(overflow), .underflow(underflow),
    .div_by_zero(div_by_zero), .invalid(invalid)
  );

  fp_div_seq #(.EXP_W(5), .MAN_W(10)) dut_half (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .opd1(h_opd1), .opd2(h_opd2), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .res(h_res), .overflow(h_overflow), .underflow(h_underflow),
    .div_by_zero(h_div_by_zero), .invalid(h_invalid)
  );

  // flags packed as {overflow, underflow, div_by_zero, invalid}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  localparam int LAT_ORD = 27;
  localparam int LAT_SP  = 1;

  vec_t        vecs[13];
  vec_t        sb_q[$];
  logic [15:0] h_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    vec_t        e;
    int          lat;
    logic [3:0]  fl;
    sb_q.push_back(v);
    @(negedge clk);
    chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    opd1 = v.a; opd2 = v.b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; opd1 = $urandom; opd2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e  = sb_q.pop_front();
    fl = {overflow, underflow, div_by_zero, invalid};
    n_vec++;
    $display("vec %h / %h -> res %h flags %b lat %0d (want %h %b %0d)",
             e.a, e.b, res, fl, lat, e.res, e.flags, e.lat);
    chk("out_valid_timeout", {31'b0, out_valid}, 32'd1);
    chk("res", res, e.res);
    chk("flags", {28'b0, fl}, {28'b0, e.flags});
    chk("latency", lat, e.lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; opd1 = $urandom; opd2 = $urandom;
      @(posedge clk); #1;
      chk("hold_res", res, e.res);
      chk("hold_flags", {28'b0, overflow, underflow, div_by_zero, invalid}, {28'b0, e.flags});
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_take", {31'b0, out_valid}, 32'd0);
    chk("in_ready_after_take", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_half(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_res);
    int          lat;
    logic [15:0] e;
    h_q.push_back(exp_res);
    @(negedge clk);
    h_opd1 = a; h_opd2 = b; h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 1;
    while (!h_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e = h_q.pop_front();
    n_vec++;
    $display("half %h / %h -> res %h lat %0d (want %h 14)", a, b, h_res, lat, e);
    chk("half_res", {16'b0, h_res}, {16'b0, e});
    chk("half_latency", lat, 14);
    chk("half_flags", {28'b0, h_overflow, h_underflow, h_div_by_zero, h_invalid}, 32'd0);
    @(negedge clk);
    h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_out_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_ORD};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, LAT_ORD};
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, LAT_ORD};
    vecs[3]  = '{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 4'b0000, LAT_ORD};
    vecs[4]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, LAT_ORD};
    vecs[5]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, LAT_SP};
    vecs[6]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, LAT_SP};
    vecs[7]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, LAT_SP};
    vecs[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0001, LAT_SP};
    vecs[9]  = '{32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, LAT_SP};
    vecs[10] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, LAT_SP};
    vecs[11] = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000, LAT_ORD};
    vecs[12] = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, LAT_ORD};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; opd1 = '0; opd2 = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b0; h_opd1 = '0; h_opd2 = '0;
    #12;
    chk("reset_res", res, 32'd0);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_flags", {28'b0, overflow, underflow, div_by_zero, invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], (i == 11) ? 10 : 0);

    // Abort an ordinary division partway through the iterations.
    @(negedge clk);
    opd1 = 32'h40C00000; opd2 = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_no_output", {31'b0, out_valid}, 32'd0);
    n_vec++;
    $display("abort at iteration 10 -> out_valid %b in_ready %b", out_valid, in_ready);
    run_vec(vecs[1], 0);

    run_half(16'h4600, 16'h4000, 16'h4200);
    run_half(16'h3C00, 16'h4200, 16'h3555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
